// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner.
//   - Col drive patterns (active-low one-hot), scanned COL_0 -> COL_3
//   - KEY_NONE: 5-bit key result, bit 4 set means "no key", low nibble is the hex code
//   - deb_state_e: debounce FSM states
//   - decode_key: maps a driven column and a single-low row to its hex code
package keypad_pkg;

   localparam logic [3:0] COL_0 = 4'b0111;
   localparam logic [3:0] COL_1 = 4'b1011;
   localparam logic [3:0] COL_2 = 4'b1101;
   localparam logic [3:0] COL_3 = 4'b1110;

   localparam logic [4:0] KEY_NONE = 5'b1_0000;

   typedef enum logic [1:0] {StIdle, StConfirm, StPressed} deb_state_e;

   // Row must contain exactly one low bit; anything else returns 0.
   function automatic logic [3:0] decode_key(input logic [3:0] col, input logic [3:0] row);
      logic [3:0] code;
      code = 4'h0;
      case (col)
         COL_0: case (row)
            4'b0111: code = 4'h1;
            4'b1011: code = 4'h4;
            4'b1101: code = 4'h7;
            4'b1110: code = 4'h0;
            default: code = 4'h0;
         endcase
         COL_1: case (row)
            4'b0111: code = 4'h2;
            4'b1011: code = 4'h5;
            4'b1101: code = 4'h8;
            4'b1110: code = 4'hF;
            default: code = 4'h0;
         endcase
         COL_2: case (row)
            4'b0111: code = 4'h3;
            4'b1011: code = 4'h6;
            4'b1101: code = 4'h9;
            4'b1110: code = 4'hE;
            default: code = 4'h0;
         endcase
         COL_3: case (row)
            4'b0111: code = 4'hA;
            4'b1011: code = 4'hB;
            4'b1101: code = 4'hC;
            4'b1110: code = 4'hD;
            default: code = 4'h0;
         endcase
         default: code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/kypd_debounce.sv
// Frame-level debounce FSM.
//   clk, rst_n    : clock, async active-low reset
//   frame_valid   : one-cycle strobe, frame_result is a new frame
//   frame_result  : 5-bit key result of the frame (KEY_NONE or {0,code})
//   stable        : debounced key result (registered)
//   press_evt     : combinational, high in the frame_valid cycle that makes a key stable
//   evt_code      : code belonging to press_evt
module kypd_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_valid,
   input  logic [4:0] frame_result,
   output logic [4:0] stable,
   output logic       press_evt,
   output logic [3:0] evt_code
);

   localparam int unsigned MW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [MW-1:0] DF = MW'(DEBOUNCE_FRAMES);

   deb_state_e    state_q, state_d;
   logic [4:0]    stable_q, stable_d;
   logic [4:0]    cand_q, cand_d;
   logic [MW-1:0] match_q, match_d;
   logic          accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         stable_q <= KEY_NONE;
         cand_q   <= KEY_NONE;
         match_q  <= '0;
      end else begin
         state_q  <= state_d;
         stable_q <= stable_d;
         cand_q   <= cand_d;
         match_q  <= match_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stable_d  = stable_q;
      cand_d    = cand_q;
      match_d   = match_q;
      accept    = 1'b0;
      press_evt = 1'b0;
      evt_code  = frame_result[3:0];
      if (frame_valid) begin
         case (state_q)
            StIdle, StPressed: begin
               if (frame_result != stable_q) begin
                  cand_d  = frame_result;
                  match_d = MW'(1);
                  if (DF == MW'(1)) accept = 1'b1;
                  else state_d = StConfirm;
               end
            end
            StConfirm: begin
               if (frame_result == stable_q) begin
                  // Candidate abandoned: stable value reasserted itself.
                  state_d = (stable_q == KEY_NONE) ? StIdle : StPressed;
               end else if (frame_result == cand_q) begin
                  match_d = match_q + MW'(1);
                  if (match_d == DF) accept = 1'b1;
               end else begin
                  cand_d  = frame_result;
                  match_d = MW'(1);
                  if (DF == MW'(1)) accept = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
         if (accept) begin
            stable_d  = frame_result;
            state_d   = (frame_result == KEY_NONE) ? StIdle : StPressed;
            press_evt = (frame_result != KEY_NONE);
         end
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with frame debounce and a single-entry event handshake.
//   clk, rst_n : clock, async active-low reset
//   Row        : keypad rows, active-low, asynchronous
//   Col        : column drive, active-low one-hot
//   key_code   : code of the last accepted press
//   key_valid  : press event pending until key_ack
//   key_ack    : consumer acknowledge
//   key_held   : debounced result is a key
//   overrun    : sticky, an event was dropped while key_valid was high
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_TICKS      = 100000,
   parameter int unsigned SETTLE          = 8,
   parameter int unsigned DEBOUNCE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] Row,
   output logic [3:0] Col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);

   localparam int unsigned CW = $clog2(SCAN_TICKS);
   localparam logic [CW-1:0] LAST_C   = CW'(SCAN_TICKS - 1);
   localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

   logic [3:0]    row_meta_q, row_sync_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    col_q;
   logic [1:0]    hits_q, hits_d;   // 0, 1, or 2 = "more than one"
   logic [3:0]    fcode_q, fcode_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          overrun_q, overrun_d;

   logic          slot_end, frame_eval, sample;
   logic [3:0]    row_low;
   logic [4:0]    frame_result;
   logic [4:0]    stable;
   logic          press_evt;
   logic [3:0]    evt_code;

   assign slot_end   = (cnt_q == LAST_C);
   assign frame_eval = slot_end && (col_q == COL_3);
   assign sample     = (cnt_q == SETTLE_C);
   assign row_low    = ~row_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q  <= 4'hF;
         row_sync_q  <= 4'hF;
         cnt_q       <= '0;
         col_q       <= COL_0;
         hits_q      <= 2'd0;
         fcode_q     <= 4'h0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         row_meta_q  <= Row;
         row_sync_q  <= row_meta_q;
         cnt_q       <= slot_end ? '0 : cnt_q + CW'(1);
         if (slot_end) col_q <= {col_q[0], col_q[3:1]};
         hits_q      <= hits_d;
         fcode_q     <= fcode_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Frame accumulation; SETTLE < SCAN_TICKS-1 so sampling never meets evaluation.
   always_comb begin
      hits_d  = hits_q;
      fcode_d = fcode_q;
      if (frame_eval) begin
         hits_d  = 2'd0;
         fcode_d = 4'h0;
      end else if (sample && (row_sync_q != 4'hF)) begin
         if ($onehot(row_low) && (hits_q == 2'd0)) begin
            hits_d  = 2'd1;
            fcode_d = decode_key(col_q, row_sync_q);
         end else begin
            hits_d = 2'd2;
         end
      end
   end

   assign frame_result = (hits_q == 2'd1) ? {1'b0, fcode_q} : KEY_NONE;

   kypd_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_valid  (frame_eval),
      .frame_result (frame_result),
      .stable       (stable),
      .press_evt    (press_evt),
      .evt_code     (evt_code)
   );

   // Single-entry event slot; an ack in the event cycle frees it for the new code.
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;
      if (press_evt) begin
         if (!key_valid_q || key_ack) begin
            key_code_d  = evt_code;
            key_valid_d = 1'b1;
            if (key_ack) overrun_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (key_ack) begin
         key_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   assign Col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overrun   = overrun_q;
   assign key_held  = (stable != KEY_NONE);

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_TICKS, default 100000, clk cycles each column is driven (1 ms at 100 MHz).
REQ-002 Parameter SETTLE, default 8, cycle offset within a column slot at which Row is sampled; SHALL be less than SCAN_TICKS-1.
REQ-003 Parameter DEBOUNCE_FRAMES, default 4, consecutive identical frames required before a key result is accepted as stable.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Row  input  4  keypad rows, active-low, asynchronous to clk.
REQ-007 Col  output  4  keypad column drive, active-low one-hot.
REQ-008 key_code  output  4  hex code of the last accepted press.
REQ-009 key_valid  output  1  press event pending; held until acknowledged.
REQ-010 key_ack  input  1  consumer acknowledge; pops the pending event.
REQ-011 key_held  output  1  high while the stable key result is a key (not none).
REQ-012 overrun  output  1  sticky flag; an event was dropped while key_valid was high.

Function
REQ-013 Row SHALL pass through a 2-flop synchronizer before use.
REQ-014 A slot counter SHALL count 0..SCAN_TICKS-1 and wrap; on wrap, Col SHALL advance 0111 -> 1011 -> 1101 -> 1110 -> 0111.
REQ-015 Synchronized Row SHALL be sampled once per slot, when the counter equals SETTLE.
REQ-016 Decode: Col 0111 with Row 0111/1011/1101/1110 -> 1/4/7/0; Col 1011 -> 2/5/8/F; Col 1101 -> 3/6/9/E; Col 1110 -> A/B/C/D.
REQ-017 A frame is four slots starting at Col 0111. Frame result: exactly one key seen -> that code; zero keys, or more than one key (multi-key or multi-row sample) -> NONE.
REQ-018 Frame evaluation SHALL occur at counter SCAN_TICKS-1 of the Col 1110 slot.
REQ-019 Debounce FSM states: IDLE (stable NONE), CONFIRM (candidate differs from stable, counting matches), PRESSED (stable key).
REQ-020 In CONFIRM, a frame equal to the candidate increments the match count; a differing frame reloads the candidate with count 1; on reaching DEBOUNCE_FRAMES the candidate becomes stable.
REQ-021 In CONFIRM, a frame equal to the current stable value returns the FSM to IDLE or PRESSED with no event.
REQ-022 A stable change to a key value (NONE->key or key->different key) SHALL generate a press event; a stable change to NONE SHALL not.
REQ-023 A press event SHALL set key_valid and load key_code on the cycle after frame evaluation (1-cycle latency).
REQ-024 key_valid SHALL stay high and key_code SHALL stay constant until a cycle with key_ack high, which clears key_valid.
REQ-025 key_ack while key_valid is low SHALL be ignored.
REQ-026 An event arriving while key_valid is high and key_ack is low SHALL be dropped and SHALL set overrun; key_code is unchanged.
REQ-027 An event in the same cycle as key_ack SHALL load the new code with key_valid remaining high and SHALL not set overrun.
REQ-028 overrun SHALL clear on the first key_ack cycle in which no new overrun occurs.

Reset
REQ-029 While rst_n is low: Col=0111, slot counter=0, FSM=IDLE, stable=NONE, key_code=0, key_valid=0, key_held=0, overrun=0, synchronizer flops=1111.
REQ-030 Assertion mid-frame SHALL abandon the frame and any pending event; scanning SHALL restart at Col 0111 slot count 0 on the first clk edge after deassertion.

Structure
REQ-031 Shared package keypad_pkg SHALL hold the Col pattern constants, the NONE encoding, the FSM state enum and the decode table function.
REQ-032 Debounce FSM and match counter SHALL be sub-module kypd_debounce (frame result in; stable value and event out); scan, sampling and handshake remain in the top level.

Verification (SCAN_TICKS=16, SETTLE=4, DEBOUNCE_FRAMES=2)
REQ-033 Reset then idle -> Col cycles 0111/1011/1101/1110 every 16 cycles; key_valid=0, key_held=0.
REQ-034 Row=1101 while Col=1101, steady for 3 frames -> key_valid=1, key_code=9, key_held=1; ack -> key_valid=0 next cycle.
REQ-035 Key 5 pressed for one frame only (bounce) -> no event; key_held stays 0.
REQ-036 Keys 1 and 2 held together -> frame result NONE; no event.
REQ-037 Press 3, no ack, release, press C -> key_code stays 3, overrun=1; ack -> key_valid=0, overrun=0.
REQ-038 rst_n low mid-frame with key_valid=1 -> all outputs take REQ-029 values asynchronously.
